// File: rtl/etch_pkg.sv
// Shared constants and enums for the sketch canvas cursor stepper.
package etch_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int PEND_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    WRITE
  } state_e;

  typedef enum logic {
    AX_X,
    AX_Y
  } axis_e;

endpackage

// File: rtl/cursor_step_ctrl_if.sv
// Pixel-write req/ack bundle between cursor stepper and frame-buffer writer.
interface cursor_step_ctrl_if;
  import etch_pkg::*;

  logic          wr_req;
  logic          wr_ack;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;

  modport master (
    output wr_req,
    output wr_x,
    output wr_y,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_x,
    input  wr_y,
    output wr_ack
  );

endinterface

// File: rtl/step_pending.sv
// Signed saturating pending-step counter for one axis.
module step_pending
  import etch_pkg::*;
#(
  parameter int W = PEND_W
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic consume,
  output logic nonzero,
  output logic sign
);

  localparam int MAXI = 2 ** (W - 1) - 1;
  localparam int MINI = -(2 ** (W - 1));

  logic signed [W-1:0] cnt_q, cnt_d;
  int s;

  // consume always pulls one unit back toward zero
  always_comb begin
    s = int'(cnt_q) + int'(inc) - int'(dec);
    if (consume) begin
      s = cnt_q[W-1] ? s + 1 : s - 1;
    end
    if (s > MAXI) s = MAXI;
    if (s < MINI) s = MINI;
    cnt_d = W'(s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nonzero = |cnt_q;
  assign sign    = cnt_q[W-1];

endmodule

// File: rtl/cursor_step_ctrl.sv
// Round-robin cursor stepper issuing pixel writes over req/ack.
// Define CURSOR_WRAP_EN to wrap at canvas edges instead of clamping.
module cursor_step_ctrl #(
  parameter int H_RES  = etch_pkg::H_RES,
  parameter int V_RES  = etch_pkg::V_RES,
  parameter int XW     = etch_pkg::XW,
  parameter int YW     = etch_pkg::YW,
  parameter int PEND_W = etch_pkg::PEND_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      x_inc,
  input  logic                      x_dec,
  input  logic                      y_inc,
  input  logic                      y_dec,
  cursor_step_ctrl_if.master        wr,
  output logic [XW-1:0]             cur_x,
  output logic [YW-1:0]             cur_y,
  output logic                      busy
);
  import etch_pkg::*;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  state_e        state_q, state_d;
  axis_e         axis_q, axis_d;
  axis_e         rr_q, rr_d;
  logic          dir_q, dir_d;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic [XW-1:0] wr_x_q, wr_x_d;
  logic [YW-1:0] wr_y_q, wr_y_d;
  logic          wr_req_q, wr_req_d;

  logic          x_nz, x_neg, y_nz, y_neg;
  logic          cons_x, cons_y;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          at_edge;

  step_pending #(.W(PEND_W)) u_pend_x (
    .clk     (clk),
    .reset   (reset),
    .inc     (x_inc),
    .dec     (x_dec),
    .consume (cons_x),
    .nonzero (x_nz),
    .sign    (x_neg)
  );

  step_pending #(.W(PEND_W)) u_pend_y (
    .clk     (clk),
    .reset   (reset),
    .inc     (y_inc),
    .dec     (y_dec),
    .consume (cons_y),
    .nonzero (y_nz),
    .sign    (y_neg)
  );

  // nx/ny hold the wrapped value at an edge; clamp mode just ignores it
  always_comb begin
    nx      = cur_x_q;
    ny      = cur_y_q;
    at_edge = 1'b0;
    if (axis_q == AX_X) begin
      if (dir_q) begin
        at_edge = (cur_x_q == '0);
        nx      = at_edge ? X_MAX : cur_x_q - 1'b1;
      end else begin
        at_edge = (cur_x_q == X_MAX);
        nx      = at_edge ? '0 : cur_x_q + 1'b1;
      end
    end else begin
      if (dir_q) begin
        at_edge = (cur_y_q == '0);
        ny      = at_edge ? Y_MAX : cur_y_q - 1'b1;
      end else begin
        at_edge = (cur_y_q == Y_MAX);
        ny      = at_edge ? '0 : cur_y_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    axis_d   = axis_q;
    rr_d     = rr_q;
    dir_d    = dir_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_req_d = wr_req_q;
    cons_x   = 1'b0;
    cons_y   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (x_nz || y_nz) begin
          unique case (1'b1)
            x_nz && y_nz: axis_d = (rr_q == AX_X) ? AX_Y : AX_X;
            x_nz && !y_nz: axis_d = AX_X;
            !x_nz && y_nz: axis_d = AX_Y;
            default: axis_d = AX_X;
          endcase
          rr_d    = axis_d;
          dir_d   = (axis_d == AX_X) ? x_neg : y_neg;
          cons_x  = (axis_d == AX_X);
          cons_y  = (axis_d == AX_Y);
          state_d = STEP;
        end
      end
      STEP: begin
        state_d = IDLE;
        if (WRAP || !at_edge) begin
          cur_x_d  = nx;
          cur_y_d  = ny;
          wr_x_d   = nx;
          wr_y_d   = ny;
          wr_req_d = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (wr.wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      axis_q   <= AX_X;
      rr_q     <= AX_X;
      dir_q    <= 1'b0;
      cur_x_q  <= XW'(H_RES / 2);
      cur_y_q  <= YW'(V_RES / 2);
      wr_x_q   <= XW'(H_RES / 2);
      wr_y_q   <= YW'(V_RES / 2);
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      axis_q   <= axis_d;
      rr_q     <= rr_d;
      dir_q    <= dir_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign wr.wr_req = wr_req_q;
  assign wr.wr_x   = wr_x_q;
  assign wr.wr_y   = wr_y_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cursor_step_ctrl.sv
// Directed and randomized bench for cursor_step_ctrl.
// Expected wrap results follow CURSOR_WRAP_EN when it is defined.
module tb_cursor_step_ctrl;
  import etch_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          x_inc, x_dec, y_inc, y_dec;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          busy;

  cursor_step_ctrl_if wif ();

  cursor_step_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .x_inc (x_inc),
    .x_dec (x_dec),
    .y_inc (y_inc),
    .y_dec (y_dec),
    .wr    (wif),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit ack_rand = 1'b0;

  int wq_x[$];
  int wq_y[$];
  int wq_c[$];
  int stab_err = 0;
  logic held = 1'b0;
  logic [XW-1:0] hx;
  logic [YW-1:0] hy;

  always @(posedge clk) cyc <= cyc + 1;

  // record every accepted write; flag any change while held
  always @(posedge clk) begin
    if (!reset && wif.wr_req) begin
      if (held && (wif.wr_x !== hx || wif.wr_y !== hy))
        stab_err <= stab_err + 1;
      if (wif.wr_ack) begin
        wq_x.push_back(int'(wif.wr_x));
        wq_y.push_back(int'(wif.wr_y));
        wq_c.push_back(cyc);
        held <= 1'b0;
      end else begin
        held <= 1'b1;
        hx   <= wif.wr_x;
        hy   <= wif.wr_y;
      end
    end else begin
      held <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (ack_rand) wif.wr_ack = 1'($urandom % 2);
    end
  endtask

  task automatic clr_q();
    wq_x.delete();
    wq_y.delete();
    wq_c.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    x_inc = 1'b0;
    x_dec = 1'b0;
    y_inc = 1'b0;
    y_dec = 1'b0;
    ack_rand = 1'b0;
    wif.wr_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
    clr_q();
  endtask

  task automatic drain();
    int quiet;
    bit ok;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      quiet = busy ? 0 : quiet + 1;
      if (quiet >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    int mx, my, px, py, bad, dx, dy;
    bit xi[10], xd[10], yi[10], yd[10];
    int n, s;

    // reset state and a single X step
    do_reset();
    chk("rst_cur_x", 32'(cur_x), 32'd320);
    chk("rst_cur_y", 32'(cur_y), 32'd240);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(wif.wr_req), 32'd0);
    chk("rst_wr_x", 32'(wif.wr_x), 32'd320);
    chk("rst_wr_y", 32'(wif.wr_y), 32'd240);
    wif.wr_ack = 1'b1;
    x_inc = 1'b1;
    tick();
    x_inc = 1'b0;
    chk("t1_e0_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_e1_busy", 32'(busy), 32'd1);
    chk("t1_e1_req", 32'(wif.wr_req), 32'd0);
    tick();
    chk("t1_e2_req", 32'(wif.wr_req), 32'd1);
    chk("t1_wr_x", 32'(wif.wr_x), 32'd321);
    chk("t1_wr_y", 32'(wif.wr_y), 32'd240);
    chk("t1_cur_x", 32'(cur_x), 32'd321);
    tick();
    chk("t1_e3_req", 32'(wif.wr_req), 32'd0);
    chk("t1_e3_busy", 32'(busy), 32'd0);
    tick(5);
    chk("t1_nwr", 32'(wq_x.size()), 32'd1);

    // simultaneous X and Y: Y wins first tie
    do_reset();
    wif.wr_ack = 1'b1;
    x_inc = 1'b1;
    y_inc = 1'b1;
    tick();
    x_inc = 1'b0;
    y_inc = 1'b0;
    tick(2);
    chk("t2_cur_y", 32'(cur_y), 32'd241);
    chk("t2_cur_x", 32'(cur_x), 32'd320);
    drain();
    chk("t2_nwr", 32'(wq_x.size()), 32'd2);
    if (wq_x.size() == 2) begin
      chk("t2_w0_y", 32'(wq_y[0]), 32'd241);
      chk("t2_w1_x", 32'(wq_x[1]), 32'd321);
      chk("t2_gap", 32'(wq_c[1] - wq_c[0]), 32'd3);
    end
    chk("t2_end_x", 32'(cur_x), 32'd321);

    // saturation at -4 with stalled ack
    do_reset();
    x_dec = 1'b1;
    tick(10);
    x_dec = 1'b0;
    tick(10);
    chk("t3_req_held", 32'(wif.wr_req), 32'd1);
    chk("t3_wr_x", 32'(wif.wr_x), 32'd319);
    chk("t3_nwr0", 32'(wq_x.size()), 32'd0);
    wif.wr_ack = 1'b1;
    drain();
    chk("t3_nwr", 32'(wq_x.size()), 32'd5);
    bad = 0;
    foreach (wq_x[i]) if (wq_x[i] != 319 - i) bad++;
    chk("t3_seq", 32'(bad), 32'd0);
    chk("t3_cur_x", 32'(cur_x), 32'd315);

    // walk to the right edge, then step past it
    do_reset();
    wif.wr_ack = 1'b1;
    for (int i = 0; i < 319; i++) begin
      x_inc = 1'b1;
      tick();
      x_inc = 1'b0;
      tick(3);
    end
    tick(2);
    chk("t4_at_edge", 32'(cur_x), 32'd639);
    clr_q();
    x_inc = 1'b1;
    tick();
    x_inc = 1'b0;
    tick();
    chk("t4_e1_busy", 32'(busy), 32'd1);
    tick();
`ifdef CURSOR_WRAP_EN
    chk("t4_wrap_req", 32'(wif.wr_req), 32'd1);
    chk("t4_wrap_x", 32'(cur_x), 32'd0);
    chk("t4_wrap_wx", 32'(wif.wr_x), 32'd0);
    chk("t4_wrap_wy", 32'(wif.wr_y), 32'd240);
    tick(5);
    chk("t4_nwr", 32'(wq_x.size()), 32'd1);
`else
    chk("t4_clamp_busy", 32'(busy), 32'd0);
    chk("t4_clamp_req", 32'(wif.wr_req), 32'd0);
    chk("t4_clamp_x", 32'(cur_x), 32'd639);
    tick(5);
    chk("t4_nwr", 32'(wq_x.size()), 32'd0);
`endif

    // inc and dec together cancel
    do_reset();
    wif.wr_ack = 1'b1;
    x_inc = 1'b1;
    x_dec = 1'b1;
    tick();
    x_inc = 1'b0;
    x_dec = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    chk("t5_busy", 32'(bad), 32'd0);
    chk("t5_nwr", 32'(wq_x.size()), 32'd0);

    // async reset mid-handshake
    do_reset();
    y_dec = 1'b1;
    tick();
    y_dec = 1'b0;
    tick(2);
    chk("t6_req", 32'(wif.wr_req), 32'd1);
    chk("t6_wr_y", 32'(wif.wr_y), 32'd239);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_req", 32'(wif.wr_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_x", 32'(cur_x), 32'd320);
    chk("t6_rst_y", 32'(cur_y), 32'd240);
    tick();
    reset = 1'b0;
    wif.wr_ack = 1'b1;
    tick(6);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_nwr", 32'(wq_x.size()), 32'd0);
    chk("t6_y", 32'(cur_y), 32'd240);

    // randomized bursts against a net-displacement model
    do_reset();
    ack_rand = 1'b1;
    mx = 320;
    my = 240;
    px = 320;
    py = 240;
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 10; k++) begin
        xi[k] = 0; xd[k] = 0; yi[k] = 0; yd[k] = 0;
      end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        s = $urandom_range(0, 9);
        if ($urandom % 2) xi[s] = 1; else xd[s] = 1;
      end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        s = $urandom_range(0, 9);
        if ($urandom % 2) yi[s] = 1; else yd[s] = 1;
      end
      for (int k = 0; k < 10; k++) begin
        x_inc = xi[k];
        x_dec = xd[k];
        y_inc = yi[k];
        y_dec = yd[k];
        mx += int'(xi[k]) - int'(xd[k]);
        my += int'(yi[k]) - int'(yd[k]);
        tick();
      end
      x_inc = 0; x_dec = 0; y_inc = 0; y_dec = 0;
      drain();
      bad = 0;
      foreach (wq_x[i]) begin
        dx = wq_x[i] - px;
        dy = wq_y[i] - py;
        if ((dx * dx + dy * dy) != 1) bad++;
        px = wq_x[i];
        py = wq_y[i];
      end
      clr_q();
      chk("rnd_adj", 32'(bad), 32'd0);
      chk("rnd_cur_x", 32'(cur_x), 32'(mx));
      chk("rnd_cur_y", 32'(cur_y), 32'(my));
      chk("rnd_wr_x", 32'(px), 32'(mx));
      chk("rnd_wr_y", 32'(py), 32'(my));
    end
    ack_rand = 1'b0;
    tick(2);
    chk("hold_stable", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
